// File: rtl/pimc_pkg.sv
// Shared types and constants for the interrupt dispatch scheduler.
package pimc_pkg;

   localparam int unsigned PIMC_PROC_W = 8;

   // One routing table entry: mask=1 keeps the line out of arbitration.
   typedef struct packed {
      logic                   mask;
      logic [PIMC_PROC_W-1:0] proc;
   } irqtab_ent_t;

   // Every line comes out of reset masked and routed to processor 0.
   localparam logic                   ENT_RST_MASK = 1'b1;
   localparam logic [PIMC_PROC_W-1:0] ENT_RST_PROC = '0;
   localparam irqtab_ent_t            ENT_RST      = '{mask: ENT_RST_MASK, proc: ENT_RST_PROC};

   // Dispatcher FSM encoding.
   localparam logic [0:0] ST_IDLE    = 1'b0;
   localparam logic [0:0] ST_PRESENT = 1'b1;

endpackage

// File: rtl/pimc_rr_arb.sv
// Combinational round-robin picker: first request at or above ptr, wrapping to 0.
module pimc_rr_arb #(
   parameter int N     = 16,
   parameter int IDX_W = 8
) (
   input  logic [N-1:0]     req,
   input  logic [IDX_W-1:0] ptr,
   output logic             grant_valid,
   output logic [IDX_W-1:0] grant_idx
);

   logic             hi_v, lo_v;
   logic [IDX_W-1:0] hi_idx, lo_idx;

   // Lowest request at/above ptr wins; otherwise lowest request below ptr (wrap).
   always_comb begin
      hi_v   = 1'b0;
      lo_v   = 1'b0;
      hi_idx = '0;
      lo_idx = '0;
      // Scan downward so the last hit in each half is the lowest index.
      for (int i = N - 1; i >= 0; i--) begin
         if (req[i]) begin
            if (i >= int'(ptr)) begin
               hi_v   = 1'b1;
               hi_idx = IDX_W'(i);
            end else begin
               lo_v   = 1'b1;
               lo_idx = IDX_W'(i);
            end
         end
      end
      grant_valid = hi_v | lo_v;
      grant_idx   = hi_v ? hi_idx : lo_idx;
   end

endmodule

// File: rtl/pimc_dispatch.sv
// Interrupt dispatch scheduler: edge-captures IRQ pins into a pending vector,
// masks/routes them through a config-programmed table and presents one
// message at a time to the core until it is acknowledged.
module pimc_dispatch #(
   parameter int IRQ_PIN_COUNT = 16,
   parameter int LINE_W        = 8,
   parameter int PROC_W        = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [IRQ_PIN_COUNT-1:0] irq_in,
   input  logic                     cfg_we,
   input  logic [LINE_W-1:0]        cfg_idx,
   input  logic [PROC_W:0]          cfg_wdata,
   output logic [PROC_W:0]          cfg_rdata,
   input  logic                     irqack,
   output logic                     notify,
   output logic [LINE_W-1:0]        lineno,
   output logic [PROC_W-1:0]        processor_id,
   output logic [IRQ_PIN_COUNT-1:0] pending
);

   import pimc_pkg::*;

   localparam logic              RST_MASK = ENT_RST.mask;
   localparam logic [PROC_W-1:0] RST_PROC = PROC_W'(ENT_RST.proc);

   logic [IRQ_PIN_COUNT-1:0] irq_prev;
   logic [IRQ_PIN_COUNT-1:0] tab_mask;
   logic [PROC_W-1:0]        tab_proc [IRQ_PIN_COUNT];
   logic [0:0]               state;
   logic [LINE_W-1:0]        rr_ptr;

   logic [IRQ_PIN_COUNT-1:0] rise;
   logic [IRQ_PIN_COUNT-1:0] ack_clr;
   logic [IRQ_PIN_COUNT-1:0] eligible;
   logic                     ack_fire;
   logic                     grant_valid;
   logic [LINE_W-1:0]        grant_idx;
   logic [LINE_W-1:0]        rr_next;
   logic [PROC_W-1:0]        grant_proc;
   logic [PROC_W:0]          rd_word;

   assign rise     = irq_in & ~irq_prev;
   assign eligible = pending & ~tab_mask;
   assign ack_fire = (state == ST_PRESENT) && irqack;
   assign rr_next  = (lineno == LINE_W'(IRQ_PIN_COUNT - 1)) ? '0 : lineno + LINE_W'(1);

   pimc_rr_arb #(
      .N     (IRQ_PIN_COUNT),
      .IDX_W (LINE_W)
   ) u_arb (
      .req         (eligible),
      .ptr         (rr_ptr),
      .grant_valid (grant_valid),
      .grant_idx   (grant_idx)
   );

   // Index decode: ack clear mask, granted line's route, and config read mux.
   // Out-of-range cfg_idx matches no entry, so reads return 0.
   always_comb begin
      ack_clr    = '0;
      grant_proc = '0;
      rd_word    = '0;
      for (int i = 0; i < IRQ_PIN_COUNT; i++) begin
         if (ack_fire && lineno == LINE_W'(i)) ack_clr[i] = 1'b1;
         if (grant_idx == LINE_W'(i))          grant_proc = tab_proc[i];
         if (cfg_idx == LINE_W'(i))            rd_word    = {tab_mask[i], tab_proc[i]};
      end
   end

   // Edge capture and pending latch; a new edge on the acked line wins over the clear.
   always_ff @(posedge clk) begin
      if (rst) begin
         irq_prev <= '0;
         pending  <= '0;
      end else begin
         irq_prev <= irq_in;
         pending  <= (pending & ~ack_clr) | rise;
      end
   end

   // Routing table and registered config read (read sees the pre-write value).
   always_ff @(posedge clk) begin
      if (rst) begin
         tab_mask  <= {IRQ_PIN_COUNT{RST_MASK}};
         cfg_rdata <= '0;
         for (int i = 0; i < IRQ_PIN_COUNT; i++) tab_proc[i] <= RST_PROC;
      end else begin
         cfg_rdata <= rd_word;
         if (cfg_we) begin
            for (int i = 0; i < IRQ_PIN_COUNT; i++) begin
               if (cfg_idx == LINE_W'(i)) begin
                  tab_mask[i] <= cfg_wdata[PROC_W];
                  tab_proc[i] <= cfg_wdata[PROC_W-1:0];
               end
            end
         end
      end
   end

   // Dispatch FSM: the message is captured at grant so later table writes
   // or masking cannot disturb it while it is presented.
   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= ST_IDLE;
         notify       <= 1'b0;
         lineno       <= '0;
         processor_id <= '0;
         rr_ptr       <= '0;
      end else if (state == ST_IDLE) begin
         if (grant_valid) begin
            state        <= ST_PRESENT;
            notify       <= 1'b1;
            lineno       <= grant_idx;
            processor_id <= grant_proc;
         end
      end else begin
         if (irqack) begin
            state  <= ST_IDLE;
            notify <= 1'b0;
            rr_ptr <= rr_next;
         end
      end
   end

endmodule

// File: tb/tb_pimc_dispatch.sv
// Directed self-checking bench for pimc_dispatch with a message scoreboard.
module tb_pimc_dispatch;

   logic        clk = 1'b0;
   logic        rst;
   logic [15:0] irq_in;
   logic        cfg_we;
   logic [7:0]  cfg_idx;
   logic [8:0]  cfg_wdata;
   logic [8:0]  cfg_rdata;
   logic        irqack;
   logic        notify;
   logic [7:0]  lineno;
   logic [7:0]  processor_id;
   logic [15:0] pending;

   int checks   = 0;
   int failures = 0;

   // Expected messages: {line, proc}.
   logic [15:0] sb [$];

   pimc_dispatch #(
      .IRQ_PIN_COUNT (16),
      .LINE_W        (8),
      .PROC_W        (8)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .irq_in       (irq_in),
      .cfg_we       (cfg_we),
      .cfg_idx      (cfg_idx),
      .cfg_wdata    (cfg_wdata),
      .cfg_rdata    (cfg_rdata),
      .irqack       (irqack),
      .notify       (notify),
      .lineno       (lineno),
      .processor_id (processor_id),
      .pending      (pending)
   );

   always #10 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic cfg_wr(input int idx, input logic [8:0] d);
      cfg_we    = 1'b1;
      cfg_idx   = 8'(idx);
      cfg_wdata = d;
      tick(1);
      cfg_we    = 1'b0;
   endtask

   task automatic cfg_rd(input int idx, input logic [8:0] exp, input string tag);
      cfg_idx = 8'(idx);
      tick(1);
      chk(tag, 32'(cfg_rdata), 32'(exp));
   endtask

   task automatic pulse(input logic [15:0] m);
      irq_in = irq_in | m;
      tick(1);
      irq_in = irq_in & ~m;
   endtask

   task automatic expect_msg(input int line, input int proc);
      sb.push_back({8'(line), 8'(proc)});
   endtask

   task automatic wait_msg(input string tag);
      int          n = 0;
      logic [15:0] e;
      while (!notify && n < 50) begin
         tick(1);
         n++;
      end
      chk({tag, "_notify"}, 32'(notify), 32'(1));
      chk({tag, "_sb"}, 32'(sb.size() != 0), 32'(1));
      if (sb.size() != 0) begin
         e = sb.pop_front();
         chk({tag, "_line"}, 32'(lineno), 32'(e[15:8]));
         chk({tag, "_proc"}, 32'(processor_id), 32'(e[7:0]));
      end
   endtask

   // Hold the message a few cycles, then ack; optionally re-pulse lines on the ack cycle.
   task automatic ack(input string tag, input logic [15:0] repulse);
      tick(2);
      chk({tag, "_hold"}, 32'(notify), 32'(1));
      irqack = 1'b1;
      irq_in = irq_in | repulse;
      tick(1);
      irqack = 1'b0;
      irq_in = irq_in & ~repulse;
      chk({tag, "_gap"}, 32'(notify), 32'(0));
   endtask

   initial begin
      logic [8:0] d;
      rst       = 1'b1;
      irq_in    = '0;
      cfg_we    = 1'b0;
      cfg_idx   = '0;
      cfg_wdata = '0;
      irqack    = 1'b0;
      tick(2);
      rst = 1'b0;

      // Reset state
      chk("rst_notify", 32'(notify), 32'(0));
      chk("rst_lineno", 32'(lineno), 32'(0));
      chk("rst_pid", 32'(processor_id), 32'(0));
      chk("rst_pending", 32'(pending), 32'(0));
      chk("rst_rdata", 32'(cfg_rdata), 32'(0));
      cfg_rd(0, 9'h100, "rst_entry0");

      // Masked line latches pending but does not dispatch until unmasked
      pulse(16'h0008);
      tick(1);
      chk("masked_pending", 32'(pending), 32'h0008);
      chk("masked_no_notify", 32'(notify), 32'(0));
      cfg_wr(3, 9'h005);
      expect_msg(3, 5);
      wait_msg("unmask3");
      ack("unmask3", 16'h0);
      chk("unmask3_clr", 32'(pending), 32'(0));

      // Fresh start, unmask all lines (line 3 -> proc 5, others -> 0x10+i)
      rst = 1'b1;
      tick(1);
      rst = 1'b0;
      for (int i = 0; i < 16; i++) begin
         d = (i == 3) ? 9'h005 : 9'(i + 16);
         cfg_wr(i, d);
      end

      // Three simultaneous edges served in order from rr_ptr=0
      pulse(16'h0224);
      expect_msg(2, 8'h12);
      expect_msg(5, 8'h15);
      expect_msg(9, 8'h19);
      wait_msg("rr2");
      ack("rr2", 16'h0);
      wait_msg("rr5");
      ack("rr5", 16'h0);
      wait_msg("rr9");
      ack("rr9", 16'h0);
      chk("rr_pending_empty", 32'(pending), 32'(0));

      // Fairness: pointer is 10, so 10 before 2
      pulse(16'h0404);
      expect_msg(10, 8'h1A);
      expect_msg(2, 8'h12);
      wait_msg("wrap10");
      ack("wrap10", 16'h0);
      wait_msg("wrap2");
      ack("wrap2", 16'h0);

      // Level held high across the ack gives one message only
      irq_in = irq_in | 16'h0010;
      expect_msg(4, 8'h14);
      wait_msg("hold4");
      ack("hold4", 16'h0);
      tick(4);
      chk("hold4_no_repend", 32'(pending), 32'(0));
      chk("hold4_no_notify", 32'(notify), 32'(0));
      irq_in = '0;
      tick(1);

      // New edge on the exact ack cycle re-pends the line
      pulse(16'h0010);
      expect_msg(4, 8'h14);
      wait_msg("rep4a");
      ack("rep4a", 16'h0010);
      chk("rep4_pending", 32'(pending), 32'h0010);
      expect_msg(4, 8'h14);
      wait_msg("rep4b");
      ack("rep4b", 16'h0);
      chk("rep4_clr", 32'(pending), 32'(0));

      // Out-of-range config index
      cfg_wr(20, 9'h0AA);
      cfg_rd(20, 9'h000, "oor_read");
      cfg_rd(4, 9'h014, "oor_no_alias");
      cfg_rd(3, 9'h005, "read3");

      // Same-cycle write and read return the old value
      cfg_we    = 1'b1;
      cfg_idx   = 8'd5;
      cfg_wdata = 9'h077;
      tick(1);
      cfg_we = 1'b0;
      chk("rdw_old", 32'(cfg_rdata), 32'h015);
      tick(1);
      chk("rdw_new", 32'(cfg_rdata), 32'h077);

      // Mask and retarget the presented line: message is unaffected
      pulse(16'h0040);
      expect_msg(6, 8'h16);
      wait_msg("pres6");
      cfg_wr(6, 9'h199);
      chk("pres6_pid", 32'(processor_id), 32'h16);
      chk("pres6_notify", 32'(notify), 32'(1));
      ack("pres6", 16'h0);

      // irqack in IDLE does not clear a (masked) pending line
      pulse(16'h0040);
      irqack = 1'b1;
      tick(1);
      irqack = 1'b0;
      chk("idle_ack_pending", 32'(pending), 32'h0040);
      chk("idle_ack_notify", 32'(notify), 32'(0));

      // Reset mid-PRESENT drops everything
      pulse(16'h0080);
      expect_msg(7, 8'h17);
      wait_msg("rst7");
      pulse(16'h0100);
      chk("rst7_pre_pending", 32'(pending), 32'h01C0);
      rst = 1'b1;
      tick(1);
      rst = 1'b0;
      chk("rst7_notify", 32'(notify), 32'(0));
      chk("rst7_lineno", 32'(lineno), 32'(0));
      chk("rst7_pid", 32'(processor_id), 32'(0));
      chk("rst7_pending", 32'(pending), 32'(0));
      cfg_rd(7, 9'h100, "rst7_entry7");
      cfg_rd(8, 9'h100, "rst7_entry8");
      tick(3);
      chk("rst7_quiet", 32'(notify), 32'(0));

      chk("sb_drained", 32'(sb.size()), 32'(0));
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
